beta_wb_stage: RTL and testbench
================================

Name: beta_wb_stage

Overview:
- Write-back stage directly downstream of the execute stage.
- Accepts each execute result that carries a register write, applies load-data alignment and sign/zero extension, and buffers the result in a small FIFO.
- Commits buffered results to the register file write port through a ready/valid handshake.
- Provides forwarding lookups for the decode stage and back-pressures execute when the FIFO is full.

Parameters:
- DataWidth, 32, width of result, register-file data and forwarding data.
- FifoDepth, 2, number of pending write entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- wb_valid_i  in  1  execute presents a register-write result this cycle
- wb_result_i  in  DataWidth  execute result (raw memory word for loads)
- wb_rd_addr_i  in  5  destination register
- wb_load_i  in  1  result is a load word requiring extraction
- wb_load_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- wb_load_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend
- wb_addr_lsb_i  in  2  load address bits [1:0]
- wb_stage_busy_o  out  1  FIFO full; execute must hold its result
- rf_wr_en_o  out  1  write request (valid) to register file
- rf_wr_addr_o  out  5  write address
- rf_wr_data_o  out  DataWidth  write data
- rf_wr_ready_i  in  1  register file accepts the write this cycle
- fwd_rs1_addr_i  in  5  decode rs1 lookup address
- fwd_rs2_addr_i  in  5  decode rs2 lookup address
- fwd_rs1_hit_o  out  1  a pending entry targets rs1 (never for x0)
- fwd_rs1_data_o  out  DataWidth  data of youngest matching entry; 0 on miss
- fwd_rs2_hit_o  out  1  same as rs1, for rs2
- fwd_rs2_data_o  out  DataWidth  same as rs1, for rs2
- wb_commit_cnt_o  out  32  count of committed register writes

Behaviour:
- Reset (async, rstn_i low):
  - FIFO empty, pointers 0, count 0.
  - All outputs 0; wb_stage_busy_o = 0.
  - Reset mid-operation discards all pending entries.
- Enqueue:
  - Occurs on a rising edge when wb_valid_i = 1 and wb_stage_busy_o = 0.
  - If wb_rd_addr_i = 0, the entry is dropped (nothing stored, counter unchanged).
  - wb_valid_i while busy is ignored; execute holds its inputs stable.
- Load extraction (combinational before storage, only when wb_load_i = 1):
  - Byte: select wb_result_i[8*lsb +: 8].
  - Half: select [16*lsb[1] +: 16]; lsb[0] is ignored.
  - Word, or size 11: pass through unchanged.
  - Extend to DataWidth per wb_load_unsigned_i.
  - wb_load_i = 0: pass wb_result_i through unchanged.
- Commit:
  - rf_wr_en_o/addr/data are registered-free views of the FIFO head; rf_wr_en_o = ~empty.
  - Dequeue on a rising edge when rf_wr_en_o & rf_wr_ready_i; wb_commit_cnt_o increments by 1 on that edge.
  - The counter wraps from 0xFFFFFFFF to 0.
  - Latency: an entry enqueued at edge N is presented at N+1 when the FIFO was empty, so the earliest commit is edge N+1.
- Simultaneous events:
  - Enqueue and dequeue on the same edge keep occupancy unchanged.
  - wb_stage_busy_o reflects occupancy == FifoDepth after the edge.
  - When full, enqueue is blocked even if a dequeue occurs; busy deasserts the cycle after the dequeue.
- Pointers: wrap modulo FifoDepth.
- Forwarding:
  - Combinational search over valid entries only.
  - Youngest matching entry wins.
  - Address 0 never hits.
  - The entry being dequeued this cycle still hits.
  - Incoming wb_valid_i data is not forwarded.
- Ordering: register-file writes occur strictly in enqueue order.

Test Plan:
- Byte load, signed: enqueue wb_result_i=0x8000FF00, size 00, lsb 01, signed, rd 5, rf_wr_ready_i=1 -> next cycle rf_wr_en_o=1, addr 5, data 0xFFFFFFFF; commit count 1.
- Half load, unsigned: wb_result_i=0x80017FFF, size 01, lsb 10, unsigned -> data 0x00008001. Same input with lsb 11 -> also 0x00008001.
- Back-pressure: rf_wr_ready_i=0, enqueue rd 1 then rd 2 -> wb_stage_busy_o=1 after the second edge; a third wb_valid_i is ignored. Raise ready for 1 cycle -> rd 1 commits, busy=0 next cycle, rd 2 still at head.
- Forwarding priority: pending rd 3 = 0x11 (older) and rd 3 = 0x22 (younger), fwd_rs1_addr_i=3 -> hit, 0x22. fwd_rs2_addr_i=0 -> no hit, data 0.
- x0 drop: enqueue rd 0 = 0xDEAD -> rf_wr_en_o stays 0, count unchanged, no forwarding hit.
- Reset mid-operation: FIFO full, assert rstn_i low asynchronously -> all outputs 0 immediately, count 0, busy 0; after release, the first new entry commits normally.

Source files
------------

// File: rtl/beta_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : beta_wb_stage
//  Purpose  : Write-back stage behind execute. Accepts register-write results,
//             aligns and extends load data, and buffers each result in a
//             small FIFO. Buffered results are committed to the register file
//             in order through a valid/ready handshake. The stage also answers
//             forwarding lookups from decode.
//  Ports    : clk_i / rstn_i           clock, asynchronous active-low reset
//             wb_*_i                   execute result and load controls
//             wb_stage_busy_o          FIFO full, execute must hold
//             rf_wr_*                  register-file write port (head view)
//             fwd_rs{1,2}_*            decode forwarding lookups
//             wb_commit_cnt_o          running count of committed writes
//  Revision : 1.0  initial release
// ============================================================================
module beta_wb_stage #(
   parameter int DataWidth = 32,
   parameter int FifoDepth = 2      // power of two, >= 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 wb_valid_i,
   input  logic [DataWidth-1:0] wb_result_i,
   input  logic [4:0]           wb_rd_addr_i,
   input  logic                 wb_load_i,
   input  logic [1:0]           wb_load_size_i,
   input  logic                 wb_load_unsigned_i,
   input  logic [1:0]           wb_addr_lsb_i,
   output logic                 wb_stage_busy_o,
   output logic                 rf_wr_en_o,
   output logic [4:0]           rf_wr_addr_o,
   output logic [DataWidth-1:0] rf_wr_data_o,
   input  logic                 rf_wr_ready_i,
   input  logic [4:0]           fwd_rs1_addr_i,
   input  logic [4:0]           fwd_rs2_addr_i,
   output logic                 fwd_rs1_hit_o,
   output logic [DataWidth-1:0] fwd_rs1_data_o,
   output logic                 fwd_rs2_hit_o,
   output logic [DataWidth-1:0] fwd_rs2_data_o,
   output logic [31:0]          wb_commit_cnt_o
);

   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]           addr_q [FifoDepth];
   logic [DataWidth-1:0] data_q [FifoDepth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q,  count_d;
   logic [31:0]          commit_cnt_q, commit_cnt_d;

   logic                 empty;
   logic                 full;
   logic                 enq;
   logic                 deq;
   logic [DataWidth-1:0] ext_data;

   assign empty = (count_q == '0);
   assign full  = (count_q == FullCnt);

   // Writes to x0 are architecturally void, so they never occupy a slot.
   assign enq = wb_valid_i & ~full & (wb_rd_addr_i != 5'd0);
   assign deq = ~empty & rf_wr_ready_i;

   // ------------------------------------------------------------------------
   // Load extraction and extension
   // ------------------------------------------------------------------------
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = wb_result_i[7:0];
      case (wb_addr_lsb_i)
         2'd0:    byte_sel = wb_result_i[7:0];
         2'd1:    byte_sel = wb_result_i[15:8];
         2'd2:    byte_sel = wb_result_i[23:16];
         default: byte_sel = wb_result_i[31:24];
      endcase
      // Halfword alignment only uses address bit 1; bit 0 is don't-care.
      half_sel = wb_addr_lsb_i[1] ? wb_result_i[31:16] : wb_result_i[15:0];

      ext_data = wb_result_i;
      if (wb_load_i) begin
         case (wb_load_size_i)
            2'b00:   ext_data = {{(DataWidth-8){~wb_load_unsigned_i & byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{(DataWidth-16){~wb_load_unsigned_i & half_sel[15]}}, half_sel};
            default: ext_data = wb_result_i;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Pointer / occupancy / counter next state
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d     = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q;
      commit_cnt_d = deq ? commit_cnt_q + 32'd1 : commit_cnt_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         commit_cnt_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            addr_q[gi] <= '0;
            data_q[gi] <= '0;
         end else if (enq && (wr_ptr_q == PtrW'(gi))) begin
            addr_q[gi] <= wb_rd_addr_i;
            data_q[gi] <= ext_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Register-file port: unregistered view of the FIFO head, zero when empty
   // ------------------------------------------------------------------------
   assign wb_stage_busy_o = full;
   assign rf_wr_en_o      = ~empty;
   assign rf_wr_addr_o    = empty ? 5'd0 : addr_q[rd_ptr_q];
   assign rf_wr_data_o    = empty ? '0 : data_q[rd_ptr_q];
   assign wb_commit_cnt_o = commit_cnt_q;

   // ------------------------------------------------------------------------
   // Forwarding: walk valid entries oldest to youngest so that the last
   // match (the youngest) wins. The head stays visible on its commit cycle.
   // ------------------------------------------------------------------------
   logic [PtrW-1:0] fwd_idx;

   always_comb begin
      fwd_rs1_hit_o  = 1'b0;
      fwd_rs1_data_o = '0;
      fwd_rs2_hit_o  = 1'b0;
      fwd_rs2_data_o = '0;
      fwd_idx        = rd_ptr_q;
      for (int k = 0; k < FifoDepth; k++) begin
         fwd_idx = rd_ptr_q + PtrW'(k);
         if (CntW'(k) < count_q) begin
            if ((fwd_rs1_addr_i != 5'd0) && (addr_q[fwd_idx] == fwd_rs1_addr_i)) begin
               fwd_rs1_hit_o  = 1'b1;
               fwd_rs1_data_o = data_q[fwd_idx];
            end
            if ((fwd_rs2_addr_i != 5'd0) && (addr_q[fwd_idx] == fwd_rs2_addr_i)) begin
               fwd_rs2_hit_o  = 1'b1;
               fwd_rs2_data_o = data_q[fwd_idx];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_beta_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beta_wb_stage
//  Purpose  : Self-checking bench for beta_wb_stage: directed scenarios plus a
//             randomized run compared against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_beta_wb_stage;

   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          wb_valid_i;
   logic [DW-1:0] wb_result_i;
   logic [4:0]    wb_rd_addr_i;
   logic          wb_load_i;
   logic [1:0]    wb_load_size_i;
   logic          wb_load_unsigned_i;
   logic [1:0]    wb_addr_lsb_i;
   logic          wb_stage_busy_o;
   logic          rf_wr_en_o;
   logic [4:0]    rf_wr_addr_o;
   logic [DW-1:0] rf_wr_data_o;
   logic          rf_wr_ready_i;
   logic [4:0]    fwd_rs1_addr_i;
   logic [4:0]    fwd_rs2_addr_i;
   logic          fwd_rs1_hit_o;
   logic [DW-1:0] fwd_rs1_data_o;
   logic          fwd_rs2_hit_o;
   logic [DW-1:0] fwd_rs2_data_o;
   logic [31:0]   wb_commit_cnt_o;

   beta_wb_stage #(.DataWidth(DW), .FifoDepth(DEPTH)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .wb_valid_i(wb_valid_i), .wb_result_i(wb_result_i), .wb_rd_addr_i(wb_rd_addr_i),
      .wb_load_i(wb_load_i), .wb_load_size_i(wb_load_size_i),
      .wb_load_unsigned_i(wb_load_unsigned_i), .wb_addr_lsb_i(wb_addr_lsb_i),
      .wb_stage_busy_o(wb_stage_busy_o),
      .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
      .rf_wr_ready_i(rf_wr_ready_i),
      .fwd_rs1_addr_i(fwd_rs1_addr_i), .fwd_rs2_addr_i(fwd_rs2_addr_i),
      .fwd_rs1_hit_o(fwd_rs1_hit_o), .fwd_rs1_data_o(fwd_rs1_data_o),
      .fwd_rs2_hit_o(fwd_rs2_hit_o), .fwd_rs2_data_o(fwd_rs2_data_o),
      .wb_commit_cnt_o(wb_commit_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_cnt = 32'd0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                        input logic ld, input logic [1:0] sz, input logic un, input logic [1:0] lsb);
      wb_valid_i = v; wb_result_i = res; wb_rd_addr_i = rd;
      wb_load_i = ld; wb_load_size_i = sz; wb_load_unsigned_i = un; wb_addr_lsb_i = lsb;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_extract(input logic [31:0] res, input logic ld,
                                             input logic [1:0] sz, input logic un,
                                             input logic [1:0] lsb);
      logic [31:0] v;
      if (!ld || sz[1]) return res;
      if (sz == 2'b00) begin
         v = (res >> (8 * lsb)) & 32'hFF;
         if (!un && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = (res >> (16 * lsb[1])) & 32'hFFFF;
         if (!un && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn_i = 1'b0; idle(); rf_wr_ready_i = 1'b0; fwd_rs1_addr_i = 5'd0; fwd_rs2_addr_i = 5'd0;
      #12;
      n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_en got %0b want 0", rf_wr_en_o); end
      n_cmp++; if (wb_stage_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", wb_stage_busy_o); end
      n_cmp++; if (wb_commit_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0h want 0", wb_commit_cnt_o); end
      n_cmp++; if (rf_wr_data_o !== 32'd0) begin n_bad++; $display("FAIL reset_data got %0h want 0", rf_wr_data_o); end
      rstn_i = 1'b1;
      exp_cnt = 32'd0;
      step();
   endtask

   task automatic test_byte_load();
      rf_wr_ready_i = 1'b1;
      drive(1'b1, 32'h8000_FF00, 5'd5, 1'b1, 2'b00, 1'b0, 2'b01);
      step();
      idle();
      n_cmp++; if (rf_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL byte_en got %0b want 1", rf_wr_en_o); end
      n_cmp++; if (rf_wr_addr_o !== 5'd5) begin n_bad++; $display("FAIL byte_addr got %0d want 5", rf_wr_addr_o); end
      n_cmp++; if (rf_wr_data_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL byte_data got %0h want ffffffff", rf_wr_data_o); end
      step();
      exp_cnt++;
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL byte_cnt got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
      n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL byte_drained got %0b want 0", rf_wr_en_o); end
   endtask

   task automatic test_half_load();
      rf_wr_ready_i = 1'b1;
      drive(1'b1, 32'h8001_7FFF, 5'd6, 1'b1, 2'b01, 1'b1, 2'b10);
      step();
      n_cmp++; if (rf_wr_data_o !== 32'h0000_8001) begin n_bad++; $display("FAIL half_lsb2 got %0h want 00008001", rf_wr_data_o); end
      drive(1'b1, 32'h8001_7FFF, 5'd6, 1'b1, 2'b01, 1'b1, 2'b11);
      step();
      idle();
      exp_cnt++;
      n_cmp++; if (rf_wr_data_o !== 32'h0000_8001) begin n_bad++; $display("FAIL half_lsb3 got %0h want 00008001", rf_wr_data_o); end
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL half_cnt got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
      step();
      exp_cnt++;
      n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL half_drained got %0b want 0", rf_wr_en_o); end
   endtask

   task automatic test_back_pressure();
      rf_wr_ready_i = 1'b0;
      drive(1'b1, 32'h101, 5'd1, 1'b0, 2'b10, 1'b0, 2'b00); step();
      n_cmp++; if (wb_stage_busy_o !== 1'b0) begin n_bad++; $display("FAIL bp_busy1 got %0b want 0", wb_stage_busy_o); end
      drive(1'b1, 32'h202, 5'd2, 1'b0, 2'b10, 1'b0, 2'b00); step();
      n_cmp++; if (wb_stage_busy_o !== 1'b1) begin n_bad++; $display("FAIL bp_busy2 got %0b want 1", wb_stage_busy_o); end
      drive(1'b1, 32'h303, 5'd7, 1'b0, 2'b10, 1'b0, 2'b00); step();
      n_cmp++; if (rf_wr_addr_o !== 5'd1) begin n_bad++; $display("FAIL bp_head got %0d want 1", rf_wr_addr_o); end
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt_hold got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
      // One ready cycle while execute keeps holding rd 7: dequeue only.
      rf_wr_ready_i = 1'b1; step();
      rf_wr_ready_i = 1'b0; idle(); exp_cnt++;
      fwd_rs1_addr_i = 5'd7; #1;
      n_cmp++; if (wb_stage_busy_o !== 1'b0) begin n_bad++; $display("FAIL bp_busy3 got %0b want 0", wb_stage_busy_o); end
      n_cmp++; if (rf_wr_addr_o !== 5'd2 || rf_wr_data_o !== 32'h202) begin n_bad++; $display("FAIL bp_head2 got %0d/%0h want 2/202", rf_wr_addr_o, rf_wr_data_o); end
      n_cmp++; if (fwd_rs1_hit_o !== 1'b0) begin n_bad++; $display("FAIL bp_ignored got hit %0b want 0", fwd_rs1_hit_o); end
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
      rf_wr_ready_i = 1'b1; step(); exp_cnt++;
      rf_wr_ready_i = 1'b0; fwd_rs1_addr_i = 5'd0;
      n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %0b want 0", rf_wr_en_o); end
   endtask

   task automatic test_fwd_priority();
      rf_wr_ready_i = 1'b0;
      drive(1'b1, 32'h11, 5'd3, 1'b0, 2'b10, 1'b0, 2'b00); step();
      drive(1'b1, 32'h22, 5'd3, 1'b0, 2'b10, 1'b0, 2'b00);
      fwd_rs1_addr_i = 5'd3; fwd_rs2_addr_i = 5'd0; #1;
      n_cmp++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h11) begin n_bad++; $display("FAIL fwd_incoming got %0b/%0h want 1/11", fwd_rs1_hit_o, fwd_rs1_data_o); end
      step(); idle(); #1;
      n_cmp++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h22) begin n_bad++; $display("FAIL fwd_youngest got %0b/%0h want 1/22", fwd_rs1_hit_o, fwd_rs1_data_o); end
      n_cmp++; if (fwd_rs2_hit_o !== 1'b0 || fwd_rs2_data_o !== 32'h0) begin n_bad++; $display("FAIL fwd_x0 got %0b/%0h want 0/0", fwd_rs2_hit_o, fwd_rs2_data_o); end
      rf_wr_ready_i = 1'b1; #1;
      n_cmp++; if (fwd_rs1_data_o !== 32'h22) begin n_bad++; $display("FAIL fwd_deq_cycle got %0h want 22", fwd_rs1_data_o); end
      step(); step(); exp_cnt += 2;
      rf_wr_ready_i = 1'b0;
      n_cmp++; if (fwd_rs1_hit_o !== 1'b0 || wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL fwd_drain got hit %0b cnt %0d want 0 cnt %0d", fwd_rs1_hit_o, wb_commit_cnt_o, exp_cnt); end
      fwd_rs1_addr_i = 5'd0;
   endtask

   task automatic test_x0_drop();
      rf_wr_ready_i = 1'b1;
      drive(1'b1, 32'hDEAD, 5'd0, 1'b0, 2'b10, 1'b0, 2'b00); step(); idle();
      n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL x0_en got %0b want 0", rf_wr_en_o); end
      n_cmp++; if (fwd_rs1_hit_o !== 1'b0) begin n_bad++; $display("FAIL x0_hit got %0b want 0", fwd_rs1_hit_o); end
      step();
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL x0_cnt got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      rf_wr_ready_i = 1'b0;
      drive(1'b1, 32'hAA, 5'd1, 1'b0, 2'b10, 1'b0, 2'b00); step();
      drive(1'b1, 32'hBB, 5'd2, 1'b0, 2'b10, 1'b0, 2'b00); step(); idle();
      n_cmp++; if (wb_stage_busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_full got %0b want 1", wb_stage_busy_o); end
      fwd_rs1_addr_i = 5'd1;
      #2 rstn_i = 1'b0;
      #1;
      n_cmp++; if (rf_wr_en_o !== 1'b0 || rf_wr_addr_o !== 5'd0 || rf_wr_data_o !== 32'd0) begin n_bad++; $display("FAIL rmid_port got %0b/%0d/%0h want 0/0/0", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o); end
      n_cmp++; if (wb_stage_busy_o !== 1'b0 || wb_commit_cnt_o !== 32'd0) begin n_bad++; $display("FAIL rmid_state got busy %0b cnt %0d want 0 0", wb_stage_busy_o, wb_commit_cnt_o); end
      n_cmp++; if (fwd_rs1_hit_o !== 1'b0 || fwd_rs1_data_o !== 32'd0) begin n_bad++; $display("FAIL rmid_fwd got %0b/%0h want 0/0", fwd_rs1_hit_o, fwd_rs1_data_o); end
      @(negedge clk_i); rstn_i = 1'b1; exp_cnt = 32'd0; fwd_rs1_addr_i = 5'd0;
      step();
      rf_wr_ready_i = 1'b1;
      drive(1'b1, 32'h44, 5'd4, 1'b0, 2'b10, 1'b0, 2'b00); step(); idle();
      n_cmp++; if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd4 || rf_wr_data_o !== 32'h44) begin n_bad++; $display("FAIL rmid_new got %0b/%0d/%0h want 1/4/44", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o); end
      step(); exp_cnt++;
      n_cmp++; if (wb_commit_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL rmid_cnt got %0d want %0d", wb_commit_cnt_o, exp_cnt); end
   endtask

   task automatic test_random();
      ent_t        q[$];
      logic [31:0] m_cnt;
      logic        e_hit1, e_hit2, do_enq, do_deq;
      logic [31:0] e_d1, e_d2;
      ent_t        e;
      // fresh start so the model and DUT agree on an empty FIFO and count 0
      rstn_i = 1'b0; idle(); rf_wr_ready_i = 1'b0; #3; rstn_i = 1'b1;
      step();
      m_cnt = 32'd0;
      for (int c = 0; c < 500; c++) begin
         // execute keeps a stalled result stable while the stage is busy
         if (!(wb_valid_i && q.size() == DEPTH)) begin
            drive(($urandom_range(0, 9) < 7), $urandom(), 5'($urandom_range(0, 7)),
                  1'($urandom()), 2'($urandom()), 1'($urandom()), 2'($urandom()));
         end
         rf_wr_ready_i  = ($urandom_range(0, 9) < 5);
         fwd_rs1_addr_i = 5'($urandom_range(0, 7));
         fwd_rs2_addr_i = 5'($urandom_range(0, 7));
         #1;
         e_hit1 = 1'b0; e_d1 = 32'd0; e_hit2 = 1'b0; e_d2 = 32'd0;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!e_hit1 && fwd_rs1_addr_i != 5'd0 && q[i].a == fwd_rs1_addr_i) begin e_hit1 = 1'b1; e_d1 = q[i].d; end
            if (!e_hit2 && fwd_rs2_addr_i != 5'd0 && q[i].a == fwd_rs2_addr_i) begin e_hit2 = 1'b1; e_d2 = q[i].d; end
         end
         n_cmp++; if (rf_wr_en_o !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_en c=%0d got %0b want %0b", c, rf_wr_en_o, (q.size() > 0)); end
         n_cmp++; if (wb_stage_busy_o !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_busy c=%0d got %0b want %0b", c, wb_stage_busy_o, (q.size() == DEPTH)); end
         if (q.size() > 0) begin
            n_cmp++; if (rf_wr_addr_o !== q[0].a || rf_wr_data_o !== q[0].d) begin n_bad++; $display("FAIL rnd_head c=%0d got %0d/%0h want %0d/%0h", c, rf_wr_addr_o, rf_wr_data_o, q[0].a, q[0].d); end
         end
         n_cmp++; if (fwd_rs1_hit_o !== e_hit1 || fwd_rs1_data_o !== e_d1) begin n_bad++; $display("FAIL rnd_fwd1 c=%0d got %0b/%0h want %0b/%0h", c, fwd_rs1_hit_o, fwd_rs1_data_o, e_hit1, e_d1); end
         n_cmp++; if (fwd_rs2_hit_o !== e_hit2 || fwd_rs2_data_o !== e_d2) begin n_bad++; $display("FAIL rnd_fwd2 c=%0d got %0b/%0h want %0b/%0h", c, fwd_rs2_hit_o, fwd_rs2_data_o, e_hit2, e_d2); end
         n_cmp++; if (wb_commit_cnt_o !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, wb_commit_cnt_o, m_cnt); end
         do_deq = (q.size() > 0) && rf_wr_ready_i;
         do_enq = wb_valid_i && (q.size() < DEPTH) && (wb_rd_addr_i != 5'd0);
         e.a = wb_rd_addr_i;
         e.d = m_extract(wb_result_i, wb_load_i, wb_load_size_i, wb_load_unsigned_i, wb_addr_lsb_i);
         step();
         if (do_deq) begin void'(q.pop_front()); m_cnt++; end
         if (do_enq) q.push_back(e);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_byte_load();
      test_half_load();
      test_back_pressure();
      test_fwd_priority();
      test_x0_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
